// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of FIFO-side signals between the round-robin scheduler and the four
// input / four output FIFOs it sequences.
interface fifo_rr_scheduler_if #(
   parameter int WORD_SIZE = 10,
   parameter int CNT_SIZE  = 8
);
   logic                   arb_en;
   logic [3:0]             in_empty;
   logic [4*WORD_SIZE-1:0] in_data;
   logic [3:0]             out_almost_full;
   logic [3:0]             in_pop;
   logic [3:0]             out_push;
   logic [WORD_SIZE-1:0]   out_data;
   logic [1:0]             state;
   logic                   idle;
   logic [CNT_SIZE-1:0]    xfer_count;

   modport master (
      output arb_en, in_empty, in_data, out_almost_full,
      input  in_pop, out_push, out_data, state, idle, xfer_count
   );

   modport slave (
      input  arb_en, in_empty, in_data, out_almost_full,
      output in_pop, out_push, out_data, state, idle, xfer_count
   );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler: pops four input FIFOs in turn and pushes each word to
// the output FIFO named by its two top bits, with a fixed 2-cycle pop-to-push latency.
module fifo_rr_scheduler #(
   parameter int WORD_SIZE = 10,
   parameter int CNT_SIZE  = 8
) (
   input logic               clk,
   input logic               reset_L,
   fifo_rr_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      STALL  = 2'd2
   } state_e;

   state_e               state_q;
   logic [1:0]           last_q;
   logic [3:0]           excl_q;
   logic                 inflightValid_q;
   logic [1:0]           inflightIdx_q;
   logic [3:0]           out_push_q;
   logic [WORD_SIZE-1:0] out_data_q;
   logic [CNT_SIZE-1:0]  xfer_count_q;

   logic [3:0]           eligible;
   logic [3:0]           pop_d;
   logic [1:0]           grant_d;
   logic [1:0]           candIdx;
   logic [WORD_SIZE-1:0] flightWord;
   logic [1:0]           flightDest;

   // The empty flag lags the read pointer by a cycle, so an input popped last
   // cycle is masked out. Descending scan leaves the input nearest last+1 as winner.
   always_comb begin
      eligible = ~bus.in_empty & ~excl_q;
      pop_d    = '0;
      grant_d  = last_q;
      candIdx  = last_q;
      if (state_q == ACTIVE && bus.arb_en && bus.out_almost_full == 4'b0000) begin
         for (int k = 4; k >= 1; k--) begin
            candIdx = last_q + 2'(k);
            if (eligible[candIdx]) begin
               grant_d = candIdx;
            end
         end
         if (eligible != 4'b0000) begin
            pop_d = 4'b0001 << grant_d;
         end
      end
   end

   always_comb begin
      flightWord = '0;
      for (int i = 0; i < 4; i++) begin
         if (inflightIdx_q == 2'(i)) begin
            flightWord = bus.in_data[i*WORD_SIZE +: WORD_SIZE];
         end
      end
      flightDest = flightWord[WORD_SIZE-1:WORD_SIZE-2];
   end

   // Words already popped are always pushed the next edge, regardless of state,
   // so the output FIFOs must reserve two entries below their almost-full mark.
   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) begin
         state_q         <= IDLE;
         last_q          <= 2'd3;
         excl_q          <= '0;
         inflightValid_q <= 1'b0;
         inflightIdx_q   <= '0;
         out_push_q      <= '0;
         out_data_q      <= '0;
         xfer_count_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.arb_en && !(&bus.in_empty)) begin
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (|bus.out_almost_full) begin
                  state_q <= STALL;
               end else if (!bus.arb_en || (&bus.in_empty)) begin
                  state_q <= IDLE;
               end
            end
            STALL: begin
               if (!bus.arb_en) begin
                  state_q <= IDLE;
               end else if (bus.out_almost_full == 4'b0000) begin
                  state_q <= ACTIVE;
               end
            end
            default: state_q <= IDLE;
         endcase

         excl_q <= pop_d;
         if (|pop_d) begin
            last_q <= grant_d;
         end
         inflightValid_q <= |pop_d;
         inflightIdx_q   <= grant_d;

         if (inflightValid_q) begin
            out_data_q   <= flightWord;
            out_push_q   <= 4'b0001 << flightDest;
            xfer_count_q <= xfer_count_q + CNT_SIZE'(1);
         end else begin
            out_push_q <= '0;
         end
      end
   end

   assign bus.in_pop     = pop_d;
   assign bus.out_push   = out_push_q;
   assign bus.out_data   = out_data_q;
   assign bus.state      = state_q;
   assign bus.xfer_count = xfer_count_q;
   assign bus.idle       = (state_q == IDLE) && !inflightValid_q && (out_push_q == 4'b0000);

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin scheduler that drains four input FIFOs of the transaction layer and routes each popped word to one of four output FIFOs, selected by the word's destination field. It drives the `rd_en` (pop) of the input FIFOs and the `wr_en` (push) of the output FIFOs. It consumes their `empty_flag` and `almost_full_flag` outputs, and it is the only block that sequences those FIFOs.

## Interface
- `WORD_SIZE`, 10, FIFO word width; bits `[WORD_SIZE-1:WORD_SIZE-2]` are the destination index (0..3).
- `CNT_SIZE`, 8, width of the transfer counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset_L`, input, 1: one clock; reset is asynchronous and active-high (asserted = 1 clears all state immediately).
- `arb_en`, input, 1: scheduler enable.
- `in_empty`, input, 4: `empty_flag` of input FIFOs 0..3.
- `in_data`, input, 4*WORD_SIZE: packed `data_out` of input FIFOs; FIFO i occupies `[i*WORD_SIZE +: WORD_SIZE]`.
- `out_almost_full`, input, 4: `almost_full_flag` of output FIFOs 0..3.
- `in_pop`, output, 4: one-hot-or-zero pop strobe to input FIFOs.
- `out_push`, output, 4: one-hot-or-zero push strobe to output FIFOs.
- `out_data`, output, WORD_SIZE: word presented to all output FIFOs.
- `state`, output, 2: IDLE=0, ACTIVE=1, STALL=2.
- `idle`, output, 1: high when state is IDLE and no word is in flight.
- `xfer_count`, output, CNT_SIZE: number of pushes since reset; wraps modulo 2^CNT_SIZE.

## Operation
- Reset values: `in_pop`=0, `out_push`=0, `out_data`=0, `state`=IDLE, `idle`=1, `xfer_count`=0, round-robin pointer `last`=3 (input 0 wins first), exclusion mask=0, in-flight register=0.
- An input i is **eligible** when `in_empty[i]`=0 and i was not popped in the previous cycle.
  - The exclusion is required because `empty_flag` lags the read pointer by one cycle.
  - A single active input therefore drains at one word per two cycles.
- `in_pop` is combinational. It asserts exactly one bit, the first eligible input after `last` in order `last+1, last+2, ...` mod 4, only when all of these hold:
  - `state`=ACTIVE;
  - `arb_en`=1;
  - `out_almost_full`==0;
  - at least one input is eligible.
- On each clock edge where `in_pop[g]`=1: `last`<=g, and the exclusion mask<={bit g}. Otherwise the exclusion mask<=0.
- State transitions, evaluated every edge:
  - IDLE -> ACTIVE when `arb_en`=1 and any `in_empty` bit is 0.
  - ACTIVE -> STALL when any `out_almost_full` bit is 1; this takes priority.
  - ACTIVE -> IDLE when `arb_en`=0 or all `in_empty` bits are 1.
  - STALL -> ACTIVE when `out_almost_full`==0 and `arb_en`=1.
  - STALL -> IDLE when `arb_en`=0.
- Destination routing: word w is pushed to output FIFO `w[WORD_SIZE-1:WORD_SIZE-2]`.
- `xfer_count` increments by 1 on every edge at which a push is issued.
- Words already popped are always completed (pushed), regardless of `arb_en`, STALL, or an `out_almost_full` assertion.

## Timing
- Pop in cycle N: the input FIFO presents the word on `in_data[g]` in cycle N+1.
  - At the edge ending N+1, the scheduler registers `out_data`<=that word and `out_push`<=onehot(dest).
  - The push is visible in cycle N+2. Pop-to-push latency is 2 cycles.
- The in-flight register records g for one cycle, so at most 2 words are in flight. Output FIFOs must set their almost-full threshold at least 2 entries below depth.
- `out_push` is a single-cycle pulse per word; it is 0 in all other cycles, and `out_data` holds its last value.
- `out_almost_full` rising in cycle N blocks the pop in cycle N itself (combinational path).
- `arb_en` falling in cycle N blocks the pop in cycle N. `idle` rises once the last in-flight push has completed and the state is IDLE.
- If `reset_L` is asserted mid-transfer, all outputs clear asynchronously and in-flight words are dropped. Operation restarts from reset values on the first edge after deassertion.
- `xfer_count` wrap: 255+1 -> 0 when `CNT_SIZE`=8, with no flag.

## Test plan
- Reset, then `arb_en`=1 and only input 2 non-empty holding words with dest 1 (0x100) and dest 3 (0x300):
  - pops occur in cycles 1 and 3;
  - `out_push`=0010 with `out_data`=0x100 in cycle 3, then `out_push`=1000 with `out_data`=0x300 in cycle 5;
  - `xfer_count`=2; state returns to IDLE; `idle`=1.
- All four inputs non-empty with 2 words each: pop order is 0,1,2,3,0,1,2,3 on consecutive cycles, and 8 pushes follow with 2-cycle latency.
- `out_almost_full[0]` raised while two words are in flight:
  - both words are still pushed;
  - `in_pop`=0 and `state`=STALL until the flag drops;
  - popping then resumes from input `last`+1.
- `arb_en` dropped one cycle after a pop: no further pops, the pending word is pushed, then `state`=IDLE and `idle`=1.
- `reset_L` asserted the cycle after a pop: `in_pop`, `out_push` and `xfer_count` go to 0 immediately; after release, the first grant goes to input 0.
- 256 transfers: `xfer_count` wraps to 0.
